// File: rtl/rpi_readback_pkg.sv
// Shared definitions for the Raspberry Pi frame readback block: byte width and FSM state encoding.
package rpi_readback_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC_ENC = 2'd1;
    localparam logic [1:0] ST_CAPTURE_ENC   = 2'd2;
    localparam logic [1:0] ST_READY_ENC     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_WAIT_SYNC = ST_WAIT_SYNC_ENC,
        ST_CAPTURE   = ST_CAPTURE_ENC,
        ST_READY     = ST_READY_ENC
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge pulse
// (one clk_100mhz cycle wide) derived from sync stage 2 against a third delay flop.
module edge_sync (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic dly_p2;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~dly_p2;

endmodule

// File: rtl/rpi_readback.sv
// Captures one sync-aligned frame of the sample byte stream into a small buffer on request
// from the Raspberry Pi, then lets the Pi step through it one byte per read_strobe edge.
module rpi_readback
    import rpi_readback_pkg::*;
#(
    parameter int ADDR_DEPTH = 4,
    parameter int MAX_ADDR   = (2**ADDR_DEPTH) - 1
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_sync,
    input  logic              arm,
    input  logic              read_strobe,
    output logic [DATA_W-1:0] RPI_OUT,
    output logic              frame_ready,
    output logic              sync_err
);

    localparam int                    DEPTH     = 2**ADDR_DEPTH;
    localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = ADDR_DEPTH'(MAX_ADDR);
    localparam logic [ADDR_DEPTH-1:0] ADDR_ONE  = ADDR_DEPTH'(1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t                state;
    state_t                state_next;
    logic [ADDR_DEPTH-1:0] wr_addr;
    logic [ADDR_DEPTH-1:0] wr_addr_next;
    logic [ADDR_DEPTH-1:0] rd_addr;
    logic [ADDR_DEPTH-1:0] rd_addr_next;
    logic                  sync_err_next;
    logic                  mem_we;
    logic [ADDR_DEPTH-1:0] mem_waddr;
    logic                  arm_rise;
    logic                  strobe_rise;

    edge_sync u_arm_sync (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .async_in   (arm),
        .rise       (arm_rise)
    );

    edge_sync u_strobe_sync (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .async_in   (read_strobe),
        .rise       (strobe_rise)
    );

    // arm takes priority over everything, including a coincident read_strobe edge
    always_comb begin
        state_next    = state;
        wr_addr_next  = wr_addr;
        rd_addr_next  = rd_addr;
        sync_err_next = sync_err;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr;

        if (arm_rise) begin
            state_next    = ST_WAIT_SYNC;
            wr_addr_next  = '0;
            sync_err_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_WAIT_SYNC: begin
                    if (sample_sync) begin
                        mem_we       = 1'b1;
                        mem_waddr    = '0;
                        wr_addr_next = ADDR_ONE;
                        state_next   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    mem_we = 1'b1;
                    // An early sync realigns the frame: its byte becomes byte 0
                    if (sample_sync && (wr_addr != '0)) begin
                        mem_waddr     = '0;
                        wr_addr_next  = ADDR_ONE;
                        sync_err_next = 1'b1;
                    end else if (wr_addr == LAST_ADDR) begin
                        wr_addr_next = '0;
                        rd_addr_next = '0;
                        state_next   = ST_READY;
                    end else begin
                        wr_addr_next = wr_addr + ADDR_ONE;
                    end
                end
                ST_READY: begin
                    if (strobe_rise) begin
                        rd_addr_next = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            sync_err    <= 1'b0;
            frame_ready <= 1'b0;
            RPI_OUT     <= '0;
        end else begin
            state       <= state_next;
            wr_addr     <= wr_addr_next;
            rd_addr     <= rd_addr_next;
            sync_err    <= sync_err_next;
            frame_ready <= (state_next == ST_READY);
            RPI_OUT     <= (state == ST_READY) ? mem[rd_addr] : '0;
        end
    end

    // Buffer is deliberately not reset; writes are gated by state, which reset forces to IDLE
    always_ff @(posedge clk_100mhz) begin
        if (mem_we) begin
            mem[mem_waddr] <= sample_data;
        end
    end

endmodule

// File: tb/tb_rpi_readback.sv
// Randomized self-checking bench for rpi_readback against a queue-based frame model.
module tb_rpi_readback;
    import rpi_readback_pkg::*;

    logic       clk_100mhz = 1'b0;
    logic       rst;
    logic [7:0] sample_data;
    logic       sample_sync;
    logic       arm;
    logic       read_strobe;
    logic [7:0] RPI_OUT;
    logic       frame_ready;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    // Frame model: bytes captured since the latest sync, plus simple phase flags
    logic [7:0] frame[$];
    bit         m_waiting;
    bit         m_capturing;
    bit         m_ready;
    bit         m_err;
    int         m_rd;

    always #5 clk_100mhz = ~clk_100mhz;

    rpi_readback dut (
        .clk_100mhz  (clk_100mhz),
        .rst         (rst),
        .sample_data (sample_data),
        .sample_sync (sample_sync),
        .arm         (arm),
        .read_strobe (read_strobe),
        .RPI_OUT     (RPI_OUT),
        .frame_ready (frame_ready),
        .sync_err    (sync_err)
    );

    task automatic cyc();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic model_reset();
        m_waiting   = 1'b0;
        m_capturing = 1'b0;
        m_ready     = 1'b0;
        m_err       = 1'b0;
        m_rd        = 0;
        frame.delete();
    endtask

    task automatic feed(input logic [7:0] b, input bit s);
        sample_data = b;
        sample_sync = s;
        cyc();
        if (m_waiting && s) begin
            frame       = {b};
            m_waiting   = 1'b0;
            m_capturing = 1'b1;
        end else if (m_capturing) begin
            if (s) begin
                frame = {b};
                m_err = 1'b1;
            end else begin
                frame.push_back(b);
            end
            if (frame.size() == 16) begin
                m_capturing = 1'b0;
                m_ready     = 1'b1;
                m_rd        = 0;
            end
        end
        checks++;
        if (frame_ready !== m_ready) begin
            errors++;
            $display("FAIL feed_frame_ready got %0b exp %0b (byte %02h)", frame_ready, m_ready, b);
        end
        checks++;
        if (sync_err !== m_err) begin
            errors++;
            $display("FAIL feed_sync_err got %0b exp %0b (byte %02h)", sync_err, m_err, b);
        end
    endtask

    task automatic do_arm();
        sample_sync = 1'b0;
        arm = 1'b1;
        repeat (4) cyc();
        arm = 1'b0;
        repeat (3) cyc();
        model_reset();
        m_waiting = 1'b1;
        checks++;
        if (frame_ready !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL arm_clear got ready=%0b err=%0b exp 0 0", frame_ready, sync_err);
        end
    endtask

    task automatic strobe_read();
        logic [7:0] old_b;
        logic [7:0] new_b;
        old_b = frame[m_rd];
        read_strobe = 1'b1;
        repeat (3) cyc();
        checks++;
        if (RPI_OUT !== old_b) begin
            errors++;
            $display("FAIL read_early got %02h exp %02h after 3 edges", RPI_OUT, old_b);
        end
        cyc();
        m_rd  = (m_rd + 1) % 16;
        new_b = frame[m_rd];
        checks++;
        if (RPI_OUT !== new_b) begin
            errors++;
            $display("FAIL read_4th_edge got %02h exp %02h (idx %0d)", RPI_OUT, new_b, m_rd);
        end
        read_strobe = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arm = 1'b0;
        read_strobe = 1'b0;
        sample_sync = 1'b0;
        sample_data = 8'h00;
        repeat (3) cyc();
        model_reset();
        checks++;
        if (RPI_OUT !== 8'h00 || frame_ready !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %02h %0b %0b exp 00 0 0", RPI_OUT, frame_ready, sync_err);
        end
        checks++;
        if (dut.state !== ST_IDLE || dut.rd_addr !== 4'd0 || dut.wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d rd=%0d wr=%0d exp 0 0 0", dut.state, dut.rd_addr, dut.wr_addr);
        end
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (frame_ready !== 1'b0 || RPI_OUT !== 8'h00) begin
            errors++;
            $display("FAIL post_reset got %0b %02h exp 0 00", frame_ready, RPI_OUT);
        end
    endtask

    task automatic test_basic_frame();
        do_arm();
        for (int i = 0; i < 16; i++) feed(8'(i), i == 0);
        sample_sync = 1'b0;
        cyc();
        checks++;
        if (RPI_OUT !== 8'h00) begin
            errors++;
            $display("FAIL basic_first_byte got %02h exp 00", RPI_OUT);
        end
        for (int i = 0; i < 16; i++) strobe_read();
    endtask

    task automatic test_sync_restart();
        do_arm();
        feed(8'h10, 1'b1);
        for (int i = 1; i < 5; i++) feed(8'h10 + 8'(i), 1'b0);
        checks++;
        if (dut.wr_addr !== 4'd5) begin
            errors++;
            $display("FAIL restart_wr_addr got %0d exp 5", dut.wr_addr);
        end
        feed(8'hA0, 1'b1);
        for (int i = 1; i < 16; i++) feed(8'hA0 + 8'(i), 1'b0);
        sample_sync = 1'b0;
        cyc();
        checks++;
        if (RPI_OUT !== 8'hA0 || sync_err !== 1'b1) begin
            errors++;
            $display("FAIL restart_first got %02h err=%0b exp a0 1", RPI_OUT, sync_err);
        end
        for (int i = 0; i < 3; i++) strobe_read();
    endtask

    task automatic test_arm_and_strobe();
        int rd_before;
        rd_before = m_rd;
        arm = 1'b1;
        read_strobe = 1'b1;
        repeat (4) cyc();
        checks++;
        if (frame_ready !== 1'b0 || sync_err !== 1'b0 || dut.state !== ST_WAIT_SYNC) begin
            errors++;
            $display("FAIL arm_wins got ready=%0b err=%0b st=%0d exp 0 0 %0d", frame_ready, sync_err, dut.state, ST_WAIT_SYNC);
        end
        arm = 1'b0;
        read_strobe = 1'b0;
        repeat (3) cyc();
        checks++;
        if (dut.rd_addr !== 4'(rd_before)) begin
            errors++;
            $display("FAIL arm_wins_rd got %0d exp %0d", dut.rd_addr, rd_before);
        end
        model_reset();
        m_waiting = 1'b1;
    endtask

    task automatic test_strobe_ignored();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            read_strobe = 1'b1;
            repeat (4) cyc();
            read_strobe = 1'b0;
            repeat (3) cyc();
        end
        checks++;
        if (dut.rd_addr !== 4'd0) begin
            errors++;
            $display("FAIL idle_strobe_rd got %0d exp 0", dut.rd_addr);
        end
        do_arm();
        for (int i = 0; i < 16; i++) begin
            read_strobe = (i < 10) ? i[1] : 1'b0;
            feed(8'($urandom), i == 0);
        end
        read_strobe = 1'b0;
        sample_sync = 1'b0;
        cyc();
        checks++;
        if (dut.rd_addr !== 4'd0 || RPI_OUT !== frame[0]) begin
            errors++;
            $display("FAIL capture_strobe got rd=%0d out=%02h exp 0 %02h", dut.rd_addr, RPI_OUT, frame[0]);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            int guard;
            bit first;
            do_arm();
            repeat ($urandom_range(0, 5)) feed(8'($urandom), 1'b0);
            guard = 0;
            first = 1'b1;
            while (!m_ready && guard < 200) begin
                feed(8'($urandom), first || ($urandom_range(0, 24) == 0));
                first = 1'b0;
                guard++;
            end
            checks++;
            if (!m_ready) begin
                errors++;
                $display("FAIL random_capture_timeout got ready=%0b exp 1", frame_ready);
            end
            // stream keeps running after the frame is complete; buffer must not change
            repeat ($urandom_range(1, 6)) feed(8'($urandom), $urandom_range(0, 1) == 1);
            sample_sync = 1'b0;
            checks++;
            if (RPI_OUT !== frame[0]) begin
                errors++;
                $display("FAIL random_first got %02h exp %02h", RPI_OUT, frame[0]);
            end
            repeat ($urandom_range(1, 20)) strobe_read();
        end
    endtask

    task automatic test_reset_mid_capture();
        int guard;
        do_arm();
        feed(8'h55, 1'b1);
        feed(8'h56, 1'b0);
        feed(8'h60, 1'b1);
        for (int i = 1; i < 7; i++) feed(8'h60 + 8'(i), 1'b0);
        checks++;
        if (dut.wr_addr !== 4'd7 || sync_err !== 1'b1) begin
            errors++;
            $display("FAIL midcap_setup got wr=%0d err=%0b exp 7 1", dut.wr_addr, sync_err);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (RPI_OUT !== 8'h00 || frame_ready !== 1'b0 || sync_err !== 1'b0 || dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL midcap_reset got %02h %0b %0b st=%0d exp 00 0 0 0", RPI_OUT, frame_ready, sync_err, dut.state);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) feed(8'($urandom), i == 0 || i == 3);
        sample_sync = 1'b0;
        checks++;
        if (dut.state !== ST_IDLE || dut.wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL no_capture_unarmed got st=%0d wr=%0d exp 0 0", dut.state, dut.wr_addr);
        end
        do_arm();
        guard = 0;
        while (!m_ready && guard < 40) begin
            feed(8'($urandom), guard == 0);
            guard++;
        end
        sample_sync = 1'b0;
        cyc();
        checks++;
        if (frame_ready !== 1'b1 || RPI_OUT !== frame[0]) begin
            errors++;
            $display("FAIL rearm_capture got ready=%0b out=%02h exp 1 %02h", frame_ready, RPI_OUT, frame[0]);
        end
        for (int i = 0; i < 4; i++) strobe_read();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_sync_restart();
        test_arm_and_strobe();
        test_strobe_ignored();
        test_random_frames();
        test_reset_mid_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpi_readback.md
RPI_READBACK -- requirements
Module: rpi_readback

Interface
REQ-001 Parameter ADDR_DEPTH, default 4, SHALL set buffer address width; depth = 2**ADDR_DEPTH bytes, minimum ADDR_DEPTH 1.
REQ-002 Parameter MAX_ADDR, default (2**ADDR_DEPTH)-1, SHALL be the last buffer address.
REQ-003 clk_100mhz  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 sample_data  in  8  byte stream to capture, synchronous to clk_100mhz, one byte per cycle.
REQ-006 sample_sync  in  1  frame marker, synchronous; high on the cycle carrying frame byte 0.
REQ-007 arm  in  1  asynchronous level from Raspberry Pi; rising edge requests a new capture.
REQ-008 read_strobe  in  1  asynchronous level from Raspberry Pi; rising edge advances the read pointer.
REQ-009 RPI_OUT  out  8  registered byte presented to the Raspberry Pi.
REQ-010 frame_ready  out  1  registered; high while a complete frame is readable.
REQ-011 sync_err  out  1  registered sticky flag; early sample_sync seen during capture.

Function
REQ-012 arm and read_strobe SHALL each pass through a 2-flop synchronizer, then a rising-edge detector comparing sync stage 2 with a third flop.
REQ-013 States SHALL be IDLE, WAIT_SYNC, CAPTURE, READY.
REQ-014 IDLE: frame_ready=0, RPI_OUT=0x00; arm edge -> WAIT_SYNC.
REQ-015 WAIT_SYNC: on sample_sync=1, write sample_data to mem[0], wr_addr<=1, -> CAPTURE; otherwise hold.
REQ-016 CAPTURE: write sample_data to mem[wr_addr] every cycle, wr_addr+1; after writing MAX_ADDR -> READY with rd_addr<=0.
REQ-017 CAPTURE with sample_sync=1 at wr_addr!=0 SHALL write that byte to mem[0], set wr_addr<=1, and set sync_err=1.
REQ-018 READY: frame_ready=1; RPI_OUT SHALL register mem[rd_addr] every cycle.
REQ-019 READY, read_strobe edge: rd_addr+1, wrapping MAX_ADDR -> 0; no other effect.
REQ-020 RPI_OUT SHALL show the next byte on the 4th rising clk edge, counting the first edge that samples read_strobe high.
REQ-021 read_strobe edges outside READY SHALL be ignored; rd_addr unchanged.
REQ-022 arm edge in WAIT_SYNC, CAPTURE or READY SHALL restart: clear sync_err, frame_ready<=0, wr_addr<=0, -> WAIT_SYNC; the partial frame is discarded.
REQ-023 Simultaneous arm and read_strobe edges in READY: arm SHALL win, no rd_addr increment.
REQ-024 sync_err SHALL clear only on arm edge or reset.
REQ-025 Buffer SHALL never be written outside WAIT_SYNC/CAPTURE; READY contents are stable.

Reset
REQ-026 rst SHALL force state IDLE, wr_addr=0, rd_addr=0, RPI_OUT=0x00, frame_ready=0, sync_err=0, all synchronizer/edge flops 0.
REQ-027 Buffer memory SHALL not be reset; contents are undefined until the first complete capture.
REQ-028 rst mid-CAPTURE or mid-READY SHALL abort with no further writes; a new arm edge is required.

Structure
REQ-029 State encoding localparams SHALL live in a shared package/include rpi_readback_pkg for bench reuse.
REQ-030 Sub-module edge_sync (2-flop sync + rising-edge pulse, async reset) SHALL be instantiated for arm and read_strobe.
REQ-031 Buffer SHALL be a single inferred 8-bit x depth array, one write port, one read port.

Verification (ADDR_DEPTH=4)
REQ-032 Reset, arm edge, stream 0x00..0x0F with sync on 0x00 -> frame_ready high 16 cycles after sync; RPI_OUT=0x00.
REQ-033 After REQ-032, 16 read_strobe edges -> RPI_OUT 0x01..0x0F then 0x00 (wrap); each change on 4th edge after strobe sampled.
REQ-034 Sync re-asserted at wr_addr=5 with byte 0xA0, then 0xA1..0xAF -> sync_err=1, readout 0xA0..0xAF.
REQ-035 read_strobe toggled in IDLE/CAPTURE -> rd_addr stays 0; first READY byte is mem[0].
REQ-036 arm and read_strobe rising together in READY -> frame_ready=0, state WAIT_SYNC, rd_addr unchanged, sync_err cleared.
REQ-037 rst at wr_addr=7 -> all outputs 0 next cycle; no capture until a new arm edge.
